ipe_mregion_periph: RTL and testbench
=====================================

Name: ipe_mregion_periph

Overview:
- Multi-region successor to the single-segment IP-encapsulation peripheral.
- Provides NUM_REGIONS independent protected code/data segments, each with its own enable, lock and entry point.
- Checks fetch, execution-unit, DMA and debug addresses, and reports the first violation in a sticky status register.
- Sits on the 16-bit peripheral bus beside the frontend and execution unit; its violation outputs drive the NMI logic.

Parameters:
- NUM_REGIONS, 4, number of protected regions (1..7).
- BASE_ADDR, 15'h0580, register block base; must be aligned to 2^DEC_WD.
- DEC_WD, 6, decoder width in bytes-address bits.
- GRAN_SHIFT, 4, segment granularity, log2 of bytes (16-byte segments).
- ENTRY_OFFSET, 8, byte offset of each region's sole legal entry point from its start.

Ports:
- mclk  in  1  main system clock
- puc_rst_n  in  1  asynchronous active-low reset
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable
- per_we  in  2  byte write enables
- per_dout  out  16  peripheral read data (0 when not selected)
- fe_pc  in  16  current fetch PC
- fe_pc_nxt  in  16  next fetch PC
- fe_decode  in  1  instruction decode strobe
- eu_mab  in  16  execution-unit memory address
- dma_addr  in  16  DMA address
- dbg_mem_addr  in  16  debug memory address
- nmi_acc  in  1  NMI accepted
- ipe_fe_violation  out  1  latched illegal-entry violation
- ipe_eu_violation  out  1  EU access violation (combinational)
- ipe_dma_violation  out  1  DMA hit on an enabled region
- ipe_dbg_violation  out  1  debug hit on an enabled region
- ipe_executing  out  1  the decoded PC lies in an enabled region
- ipe_region_id  out  3  index of the executing region; 7 when none

Behaviour:
- Register map (byte offsets), region r at 8*r:
  - +0 CTL: bit0 enable, bit1 lock.
  - +2 SEGB1: [12:0] start segment.
  - +4 SEGB2: [12:0] end segment, exclusive.
  - +6: reserved, reads 0.
- STATUS is at 8*NUM_REGIONS:
  - bit15 valid.
  - [7:4] type one-hot: fe, eu, dma, dbg.
  - [2:0] region.
  - Writing 1 to bit15 clears it.
- Lock: once CTL.lock=1, writes to that region's CTL, SEGB1 and SEGB2 are ignored until reset. Byte writes behave as word writes.
- Address-in-region r: enable_r & ((addr>>GRAN_SHIFT) >= SEGB1_r) & ((addr>>GRAN_SHIFT) < SEGB2_r), using a 16-bit unsigned compare.
  - SEGB2 <= SEGB1 means an empty region.
  - Overlapping regions resolve to the lowest index.
- buff_pc is loaded with fe_pc on fe_decode. Executing region = lowest-index region containing buff_pc. ipe_executing and ipe_region_id are derived from buff_pc.
- EU violation: eu_mab is in region r and r differs from the executing region (including no region).
- DMA and debug violations: address is in any enabled region, combinational.
- Fetch violation candidate: fe_pc_nxt is in region r, fe_pc is not in r, and fe_pc_nxt != (SEGB1_r<<GRAN_SHIFT)+ENTRY_OFFSET. Entry-address arithmetic is mod 2^16.
- Fetch violation latch:
  - Sets on the candidate.
  - Clears on nmi_acc; a candidate in the same cycle wins.
  - Output = latch & ~nmi_acc.
- STATUS capture:
  - Occurs on any violation while valid=0.
  - Type priority fe > eu > dma > dbg.
  - Region = violating region index.
  - While valid=1 there is no overwrite (first violation kept).
  - Capture and a software clear in the same cycle: capture wins.
- Reset values:
  - All registers 0.
  - buff_pc 0.
  - Latch 0.
  - per_dout 0.
  - ipe_region_id 7, ipe_executing 0, all violations 0.
  - Asserting reset mid-operation clears everything immediately, including locks.
- Read latency: combinational per_dout in the same cycle as per_en with per_we=0.

Test Plan:
- Program region0 SEGB1=0x0E00, SEGB2=0x0E10, CTL=1; jump from 0xC000 to 0xE008 -> no violation. Jump to 0xE010 -> ipe_fe_violation=1, STATUS=0x8010.
- Executing at 0xE020 in region0, read eu_mab=0xE050 -> no violation. Same read from PC 0xC000 -> ipe_eu_violation=1, STATUS region 0 type eu.
- Region1 at 0x0F00..0x0F10 locked, write SEGB1=0 -> readback stays 0x0F00. Assert puc_rst_n=0 -> readback 0, lock cleared.
- fe candidate in the same cycle as nmi_acc -> latch stays 1. Next cycle nmi_acc alone -> latch 0, output 0.
- DMA hit on region2 with STATUS valid already set by region0 eu -> ipe_dma_violation=1, STATUS unchanged. Write 0x8000 -> valid=0.
- Overlap: region0 and region1 both cover 0xE000, buff_pc=0xE000 -> ipe_region_id=0. Region with SEGB2=SEGB1 -> never hits.

Source files
------------

// File: rtl/ipe_mregion_periph_if.sv
// Peripheral bus bundle shared by the IPE region checker and its bus master.
interface ipe_mregion_periph_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (output per_addr, per_din, per_en, per_we, input per_dout);
    modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/ipe_mregion_periph.sv
// Multi-region IP encapsulation checker: per-region enable/lock/segment bounds,
// entry-point enforcement on fetch, EU/DMA/debug access checks and a sticky STATUS.
module ipe_mregion_periph #(
    parameter int          NUM_REGIONS  = 4,
    parameter logic [14:0] BASE_ADDR    = 15'h0580,
    parameter int          DEC_WD       = 6,
    parameter int          GRAN_SHIFT   = 4,
    parameter int          ENTRY_OFFSET = 8
) (
    input  logic                 mclk,
    input  logic                 puc_rst_n,
    ipe_mregion_periph_if.slave  per,
    input  logic [15:0]          fe_pc,
    input  logic [15:0]          fe_pc_nxt,
    input  logic                 fe_decode,
    input  logic [15:0]          eu_mab,
    input  logic [15:0]          dma_addr,
    input  logic [15:0]          dbg_mem_addr,
    input  logic                 nmi_acc,
    output logic                 ipe_fe_violation,
    output logic                 ipe_eu_violation,
    output logic                 ipe_dma_violation,
    output logic                 ipe_dbg_violation,
    output logic                 ipe_executing,
    output logic [2:0]           ipe_region_id
);

    localparam int WW = DEC_WD - 1;
    localparam logic [WW-1:0] STAT_WOFF = WW'(4 * NUM_REGIONS);

    function automatic logic in_rgn(input logic [15:0] a, input logic en,
                                    input logic [12:0] b1, input logic [12:0] b2);
        logic [15:0] seg;
        seg = a >> GRAN_SHIFT;
        return en && (seg >= {3'b000, b1}) && (seg < {3'b000, b2});
    endfunction

    function automatic logic [15:0] entry_of(input logic [12:0] b1);
        return ({3'b000, b1} << GRAN_SHIFT) + 16'(ENTRY_OFFSET);
    endfunction

    logic [1:0]  ctl_q   [NUM_REGIONS];
    logic [1:0]  ctl_d   [NUM_REGIONS];
    logic [12:0] segb1_q [NUM_REGIONS];
    logic [12:0] segb1_d [NUM_REGIONS];
    logic [12:0] segb2_q [NUM_REGIONS];
    logic [12:0] segb2_d [NUM_REGIONS];
    logic [15:0] buff_pc_q, buff_pc_d;
    logic        fe_lat_q, fe_lat_d;
    logic        st_valid_q, st_valid_d;
    logic [3:0]  st_type_q, st_type_d;
    logic [2:0]  st_rgn_q, st_rgn_d;

    logic          reg_sel, reg_wr, reg_rd;
    logic [WW-1:0] woff;
    logic [15:0]   rdata;
    logic          unused_din;

    assign reg_sel    = per.per_en && (per.per_addr[13:WW] == BASE_ADDR[14:DEC_WD]);
    assign reg_wr     = reg_sel && (per.per_we != 2'b00);
    assign reg_rd     = reg_sel && (per.per_we == 2'b00);
    assign woff       = per.per_addr[WW-1:0];
    assign unused_din = ^per.per_din[14:13];

    logic       exec_hit, eu_hit, dma_hit, dbg_hit, fe_cand, eu_viol;
    logic [2:0] exec_id, eu_id, dma_id, dbg_id, fe_id;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        exec_hit = 1'b0; exec_id = 3'd7;
        eu_hit   = 1'b0; eu_id   = 3'd0;
        dma_hit  = 1'b0; dma_id  = 3'd0;
        dbg_hit  = 1'b0; dbg_id  = 3'd0;
        fe_cand  = 1'b0; fe_id   = 3'd0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (in_rgn(buff_pc_q, ctl_q[r][0], segb1_q[r], segb2_q[r])) begin
                exec_hit = 1'b1; exec_id = 3'(r);
            end
            if (in_rgn(eu_mab, ctl_q[r][0], segb1_q[r], segb2_q[r])) begin
                eu_hit = 1'b1; eu_id = 3'(r);
            end
            if (in_rgn(dma_addr, ctl_q[r][0], segb1_q[r], segb2_q[r])) begin
                dma_hit = 1'b1; dma_id = 3'(r);
            end
            if (in_rgn(dbg_mem_addr, ctl_q[r][0], segb1_q[r], segb2_q[r])) begin
                dbg_hit = 1'b1; dbg_id = 3'(r);
            end
            if (in_rgn(fe_pc_nxt, ctl_q[r][0], segb1_q[r], segb2_q[r]) &&
                !in_rgn(fe_pc, ctl_q[r][0], segb1_q[r], segb2_q[r]) &&
                (fe_pc_nxt != entry_of(segb1_q[r]))) begin
                fe_cand = 1'b1; fe_id = 3'(r);
            end
        end
    end

    assign eu_viol = eu_hit && (eu_id != exec_id);

    always_comb begin
        ctl_d      = ctl_q;
        segb1_d    = segb1_q;
        segb2_d    = segb2_q;
        buff_pc_d  = fe_decode ? fe_pc : buff_pc_q;
        fe_lat_d   = fe_cand | (fe_lat_q & ~nmi_acc);
        st_valid_d = st_valid_q;
        st_type_d  = st_type_q;
        st_rgn_d   = st_rgn_q;

        // A capture can only happen while valid is clear, so it naturally beats a clear.
        if (!st_valid_q && (fe_cand || eu_viol || dma_hit || dbg_hit)) begin
            st_valid_d = 1'b1;
            if (fe_cand) begin
                st_type_d = 4'b0001; st_rgn_d = fe_id;
            end else if (eu_viol) begin
                st_type_d = 4'b0010; st_rgn_d = eu_id;
            end else if (dma_hit) begin
                st_type_d = 4'b0100; st_rgn_d = dma_id;
            end else begin
                st_type_d = 4'b1000; st_rgn_d = dbg_id;
            end
        end else if (reg_wr && (woff == STAT_WOFF) && per.per_din[15]) begin
            st_valid_d = 1'b0;
        end

        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (reg_wr && (woff[WW-1:2] == (WW-2)'(r)) && !ctl_q[r][1]) begin
                case (woff[1:0])
                    2'd0:    ctl_d[r]   = per.per_din[1:0];
                    2'd1:    segb1_d[r] = per.per_din[12:0];
                    2'd2:    segb2_d[r] = per.per_din[12:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (reg_rd) begin
            if (woff == STAT_WOFF)
                rdata = {st_valid_q, 7'b0, st_type_q, 1'b0, st_rgn_q};
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (woff[WW-1:2] == (WW-2)'(r)) begin
                    case (woff[1:0])
                        2'd0:    rdata = {14'b0, ctl_q[r]};
                        2'd1:    rdata = {3'b0, segb1_q[r]};
                        2'd2:    rdata = {3'b0, segb2_q[r]};
                        default: rdata = 16'h0000;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                ctl_q[r]   <= '0;
                segb1_q[r] <= '0;
                segb2_q[r] <= '0;
            end
            buff_pc_q  <= '0;
            fe_lat_q   <= 1'b0;
            st_valid_q <= 1'b0;
            st_type_q  <= '0;
            st_rgn_q   <= '0;
        end else begin
            ctl_q      <= ctl_d;
            segb1_q    <= segb1_d;
            segb2_q    <= segb2_d;
            buff_pc_q  <= buff_pc_d;
            fe_lat_q   <= fe_lat_d;
            st_valid_q <= st_valid_d;
            st_type_q  <= st_type_d;
            st_rgn_q   <= st_rgn_d;
        end
    end

    assign per.per_dout        = rdata;
    assign ipe_fe_violation    = fe_lat_q & ~nmi_acc;
    assign ipe_eu_violation    = eu_viol;
    assign ipe_dma_violation   = dma_hit;
    assign ipe_dbg_violation   = dbg_hit;
    assign ipe_executing       = exec_hit;
    assign ipe_region_id       = exec_id;

endmodule

// File: tb/tb_ipe_mregion_periph.sv
// Directed scenarios plus randomized traffic against a byte-range reference model.
module tb_ipe_mregion_periph;
    localparam int NR   = 4;
    localparam int BASE = 'h0580;
    localparam int STAT = 8 * NR;

    logic mclk = 1'b0;
    logic puc_rst_n;
    always #5 mclk = ~mclk;

    ipe_mregion_periph_if bus();
    logic [15:0] fe_pc, fe_pc_nxt, eu_mab, dma_addr, dbg_mem_addr;
    logic        fe_decode, nmi_acc;
    logic        fe_v, eu_v, dma_v, dbg_v, exe;
    logic [2:0]  rid;

    ipe_mregion_periph #(.NUM_REGIONS(NR)) dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n), .per(bus),
        .fe_pc(fe_pc), .fe_pc_nxt(fe_pc_nxt), .fe_decode(fe_decode),
        .eu_mab(eu_mab), .dma_addr(dma_addr), .dbg_mem_addr(dbg_mem_addr),
        .nmi_acc(nmi_acc),
        .ipe_fe_violation(fe_v), .ipe_eu_violation(eu_v),
        .ipe_dma_violation(dma_v), .ipe_dbg_violation(dbg_v),
        .ipe_executing(exe), .ipe_region_id(rid)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: regions held as segment numbers, compared in byte space.
    int m_ctl[NR], m_b1[NR], m_b2[NR];
    int m_pc, m_type, m_reg;
    bit m_lat, m_val;

    task automatic m_reset();
        for (int r = 0; r < NR; r++) begin
            m_ctl[r] = 0; m_b1[r] = 0; m_b2[r] = 0;
        end
        m_pc = 0; m_type = 0; m_reg = 0; m_lat = 0; m_val = 0;
    endtask

    function automatic bit m_in(input int a, input int r);
        return (m_ctl[r] & 1) != 0 && a >= m_b1[r] * 16 && a < m_b2[r] * 16;
    endfunction

    function automatic int m_find(input int a);
        for (int r = 0; r < NR; r++) if (m_in(a, r)) return r;
        return -1;
    endfunction

    function automatic int m_fe(input int pc, input int nxt);
        for (int r = 0; r < NR; r++)
            if (m_in(nxt, r) && !m_in(pc, r) && nxt != ((m_b1[r] * 16 + 8) % 65536)) return r;
        return -1;
    endfunction

    function automatic int m_read(input int waddr);
        int off;
        off = waddr * 2 - BASE;
        if (off < 0 || off >= 64) return 0;
        if (off == STAT) return (int'(m_val) << 15) | (m_type << 4) | m_reg;
        if (off / 8 >= NR) return 0;
        case ((off % 8) / 2)
            0: return m_ctl[off / 8];
            1: return m_b1[off / 8];
            2: return m_b2[off / 8];
            default: return 0;
        endcase
    endfunction

    task automatic check_outputs();
        int ex, e, exp_dout;
        ex = m_find(int'(m_pc));
        e  = m_find(int'(eu_mab));
        exp_dout = (bus.per_en && bus.per_we == 2'b00) ? m_read(int'(bus.per_addr)) : 0;
        chk("executing", 16'(exe), 16'(ex >= 0));
        chk("region_id", 16'(rid), 16'(ex < 0 ? 7 : ex));
        chk("eu_viol",   16'(eu_v), 16'(e >= 0 && e != ex));
        chk("dma_viol",  16'(dma_v), 16'(m_find(int'(dma_addr)) >= 0));
        chk("dbg_viol",  16'(dbg_v), 16'(m_find(int'(dbg_mem_addr)) >= 0));
        chk("fe_viol",   16'(fe_v), 16'(m_lat && !nmi_acc));
        chk("per_dout",  bus.per_dout, 16'(exp_dout));
    endtask

    task automatic m_step();
        int ex, e, d, g, f, off, din;
        bit eu_bad, wr;
        ex  = m_find(int'(m_pc));
        e   = m_find(int'(eu_mab));
        d   = m_find(int'(dma_addr));
        g   = m_find(int'(dbg_mem_addr));
        f   = m_fe(int'(fe_pc), int'(fe_pc_nxt));
        eu_bad = (e >= 0) && (e != ex);
        off = int'(bus.per_addr) * 2 - BASE;
        din = int'(bus.per_din);
        wr  = bus.per_en && bus.per_we != 2'b00 && off >= 0 && off < 64;
        if (!m_val && (f >= 0 || eu_bad || d >= 0 || g >= 0)) begin
            m_val = 1;
            if (f >= 0)      begin m_type = 1; m_reg = f; end
            else if (eu_bad) begin m_type = 2; m_reg = e; end
            else if (d >= 0) begin m_type = 4; m_reg = d; end
            else             begin m_type = 8; m_reg = g; end
        end else if (wr && off == STAT && din[15]) begin
            m_val = 0;
        end
        if (wr && off / 8 < NR && (m_ctl[off / 8] & 2) == 0) begin
            case ((off % 8) / 2)
                0: m_ctl[off / 8] = din & 3;
                1: m_b1[off / 8]  = din & 'h1FFF;
                2: m_b2[off / 8]  = din & 'h1FFF;
                default: ;
            endcase
        end
        m_lat = (f >= 0) ? 1'b1 : (nmi_acc ? 1'b0 : m_lat);
        if (fe_decode) m_pc = int'(fe_pc);
    endtask

    task automatic tick();
        #2;
        check_outputs();
        @(posedge mclk);
        if (puc_rst_n) m_step(); else m_reset();
        #1;
    endtask

    task automatic wr(input int off, input int data);
        bus.per_en = 1'b1;
        bus.per_we = 2'($urandom_range(1, 3));
        bus.per_addr = 14'((BASE + off) >> 1);
        bus.per_din = 16'(data);
        tick();
        bus.per_en = 1'b0;
        bus.per_we = 2'b00;
    endtask

    task automatic rd_const(input string tag, input int off, input int exp);
        bus.per_en = 1'b1;
        bus.per_we = 2'b00;
        bus.per_addr = 14'((BASE + off) >> 1);
        #2;
        chk(tag, bus.per_dout, 16'(exp));
        tick();
        bus.per_en = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        int r, k;
        r = int'($urandom % NR);
        k = int'($urandom % 4);
        case (k)
            0: return 16'($urandom);
            1: return 16'(m_b1[r] * 16 + int'($urandom_range(0, 2)) - 1);
            2: return 16'(m_b1[r] * 16 + 8);
            default: return 16'(m_b2[r] * 16 - 1 + int'($urandom_range(0, 1)));
        endcase
    endfunction

    initial begin
        puc_rst_n = 1'b0;
        bus.per_en = 1'b0; bus.per_we = 2'b00; bus.per_addr = '0; bus.per_din = '0;
        fe_pc = '0; fe_pc_nxt = '0; fe_decode = 1'b0; eu_mab = '0;
        dma_addr = '0; dbg_mem_addr = '0; nmi_acc = 1'b0;
        m_reset();
        #1;
        chk("rst_region_id", 16'(rid), 16'd7);
        check_outputs();
        @(posedge mclk); @(posedge mclk); #1;
        puc_rst_n = 1'b1;

        // Entry-point check on region 0
        wr(2, 'h0E00); wr(4, 'h0E10); wr(0, 1);
        fe_pc = 'hC000; fe_pc_nxt = 'hE008; tick();
        fe_pc = 'hE008; fe_pc_nxt = 'hE00A; #2; chk("entry_legal", 16'(fe_v), 0); tick();
        fe_pc = 'hC000; fe_pc_nxt = 'hE010; tick();
        fe_pc = 'hE010; fe_pc_nxt = 'hE012; #2; chk("entry_illegal", 16'(fe_v), 1); tick();
        rd_const("status_fe", STAT, 'h8010);
        nmi_acc = 1'b1; tick(); nmi_acc = 1'b0;
        wr(STAT, 'h8000);

        // EU access from inside and outside the region
        fe_pc = 'hE020; fe_pc_nxt = 'hE022; fe_decode = 1'b1; tick(); fe_decode = 1'b0;
        eu_mab = 'hE050; #2; chk("eu_inside", 16'(eu_v), 0); tick();
        fe_pc = 'hC000; fe_pc_nxt = 'hC002; fe_decode = 1'b1; tick(); fe_decode = 1'b0;
        #2; chk("eu_outside", 16'(eu_v), 1); tick();
        rd_const("status_eu", STAT, 'h8020);
        eu_mab = '0;

        // Lock, then reset clears the lock
        wr('h0A, 'h0F00); wr('h0C, 'h0F10); wr('h08, 3); wr('h0A, 0);
        rd_const("lock_hold", 'h0A, 'h0F00);
        puc_rst_n = 1'b0; m_reset();
        bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = 14'((BASE + 'h0A) >> 1);
        #2; chk("reset_clears", bus.per_dout, 0); tick();
        puc_rst_n = 1'b1; bus.per_en = 1'b0;
        wr('h0A, 'h0123);
        rd_const("unlocked", 'h0A, 'h0123);

        // Latch vs nmi_acc
        wr(2, 'h0E00); wr(4, 'h0E10); wr(0, 1);
        fe_pc = 'hC000; fe_pc_nxt = 'hE010; tick();
        nmi_acc = 1'b1; tick();
        fe_pc_nxt = 'hC002; nmi_acc = 1'b0; #2; chk("fe_kept", 16'(fe_v), 1); tick();
        nmi_acc = 1'b1; #2; chk("fe_masked", 16'(fe_v), 0); tick();
        nmi_acc = 1'b0; #2; chk("fe_cleared", 16'(fe_v), 0); tick();
        wr(STAT, 'h8000);

        // DMA hit while STATUS already holds an EU record
        wr('h12, 'h0D00); wr('h14, 'h0D10); wr('h10, 1);
        eu_mab = 'hE050; tick(); tick();
        rd_const("status_eu2", STAT, 'h8020);
        eu_mab = '0; dma_addr = 'hD000; #2; chk("dma_hit", 16'(dma_v), 1); tick();
        rd_const("status_kept", STAT, 'h8020);
        dma_addr = '0;
        wr(STAT, 'h8000);
        bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = 14'((BASE + STAT) >> 1);
        #2; chk("status_cleared", bus.per_dout & 16'h8000, 0); tick();
        bus.per_en = 1'b0;

        // Overlap and empty regions
        wr('h0A, 'h0E00); wr('h0C, 'h0E20); wr('h08, 1);
        fe_pc = 'hE000; fe_pc_nxt = 'hE002; fe_decode = 1'b1; tick(); fe_decode = 1'b0;
        #2; chk("overlap_lowest", 16'(rid), 0); tick();
        wr('h1A, 'h0C00); wr('h1C, 'h0C00); wr('h18, 1);
        dma_addr = 'hC000; #2; chk("empty_region", 16'(dma_v), 0); tick();
        dma_addr = '0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int sel, off, data;
            fe_pc        = pick();
            fe_pc_nxt    = ($urandom % 2 == 0) ? pick() : fe_pc + 16'd2;
            fe_decode    = ($urandom % 2 == 0);
            eu_mab       = pick();
            dma_addr     = pick();
            dbg_mem_addr = pick();
            nmi_acc      = ($urandom % 4 == 0);
            sel = int'($urandom % 10);
            if (sel == 0) begin
                off = int'($urandom % (4 * NR)) * 2;
                if ((off % 8) == 0) data = int'($urandom & 'hFFFF) & (($urandom % 6 == 0) ? 'hFFFF : 'hFFFD);
                else data = int'($urandom & 'hE000) | int'($urandom_range('h0C00, 'h0C40));
                bus.per_en = 1'b1; bus.per_we = 2'($urandom_range(1, 3));
                bus.per_addr = 14'((BASE + off) >> 1); bus.per_din = 16'(data);
            end else if (sel == 1) begin
                bus.per_en = 1'b1; bus.per_we = 2'($urandom_range(1, 3));
                bus.per_addr = 14'((BASE + STAT) >> 1); bus.per_din = 16'($urandom);
            end else if (sel <= 3) begin
                bus.per_en = 1'b1; bus.per_we = 2'b00;
                bus.per_addr = 14'((BASE >> 1) + int'($urandom % 32));
            end else if (sel == 4) begin
                bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = 14'($urandom);
            end
            if ($urandom % 120 == 0) begin
                puc_rst_n = 1'b0; m_reset();
            end
            tick();
            puc_rst_n = 1'b1;
            bus.per_en = 1'b0; bus.per_we = 2'b00;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
